// File: rtl/hm_pkg.sv
// Shared constants and types for the heart-rate monitor blocks.
// The monitor's x6 BPM scaling assumes the default 10 s counting window.
package hm_pkg;

    localparam int COUNT_W           = 8;
    localparam int DEF_CLKS_PER_TICK = 1000;
    localparam int DEF_WINDOW_TICKS  = 10000;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        LOCKOUT
    } state_t;

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pulse_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, followed by a rising-edge detector.
// Also intended for reuse on the fall sensor input.
module pulse_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) sync_reg[gi] <= 1'b0;
                    else       sync_reg[gi] <= din;
                end
            end else begin : g_next
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) sync_reg[gi] <= 1'b0;
                    else       sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev_reg <= 1'b0;
        else       prev_reg <= sync_reg[SYNC_STAGES-1];
    end

    assign rise = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/pulse_window_counter.sv
// Counts synchronised pulse edges over back-to-back fixed windows and strobes the saturated count.
// Optional post-pulse lockout is built only when PULSE_REFRACTORY_EN is defined.
module pulse_window_counter
    import hm_pkg::*;
#(
    parameter int CLKS_PER_TICK    = DEF_CLKS_PER_TICK,
    parameter int WINDOW_TICKS     = DEF_WINDOW_TICKS,
    parameter int SYNC_STAGES      = 2,
    parameter int REFRACTORY_TICKS = 250
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               pulse_in,
    output logic [COUNT_W-1:0] pulse_count,
    output logic               count_valid,
    output logic               overflow,
    output logic               window_active
);

    localparam int PRE_W = cnt_w(CLKS_PER_TICK);
    localparam int WIN_W = cnt_w(WINDOW_TICKS);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLKS_PER_TICK - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_TICKS - 1);

    generate
        if (SYNC_STAGES < 2 || CLKS_PER_TICK < 1 || WINDOW_TICKS < 1 || REFRACTORY_TICKS < 1) begin : g_bad_params
            $error("pulse_window_counter: invalid parameter value");
        end
    endgenerate

    state_t             state_reg, state_next;
    logic [PRE_W-1:0]   presc_reg;
    logic [WIN_W-1:0]   win_reg;
    logic [COUNT_W:0]   acc_reg;
    logic [COUNT_W:0]   acc_sum;
    logic               edge_det;
    logic               running;
    logic               tick;
    logic               window_end;
    logic               edge_cnt;

    pulse_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (pulse_in),
        .rise  (edge_det)
    );

    // Dropping enable takes effect in the same cycle: nothing counts and no strobe fires.
    assign running    = enable && (state_reg != IDLE);
    assign tick       = running && (presc_reg == PRE_LAST);
    assign window_end = tick && (win_reg == WIN_LAST);
    assign edge_cnt   = running && (state_reg == ARMED) && edge_det;
    // acc_reg saturates at 256, so this sum never exceeds 257 and bit COUNT_W flags overflow.
    assign acc_sum    = acc_reg + {{COUNT_W{1'b0}}, edge_cnt};

`ifdef PULSE_REFRACTORY_EN
    localparam int REF_W = cnt_w(REFRACTORY_TICKS);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRACTORY_TICKS - 1);

    logic [REF_W-1:0] ref_reg;
    logic             ref_done;

    assign ref_done = tick && (ref_reg == REF_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ref_reg <= '0;
        else if (!running || state_reg != LOCKOUT)
            ref_reg <= '0;
        else if (tick)
            ref_reg <= ref_done ? '0 : ref_reg + 1'b1;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: state_next = ARMED;
                ARMED: begin
`ifdef PULSE_REFRACTORY_EN
                    if (edge_cnt) state_next = LOCKOUT;
`endif
                end
                LOCKOUT: begin
`ifdef PULSE_REFRACTORY_EN
                    if (ref_done) state_next = ARMED;
`else
                    state_next = IDLE;
`endif
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_reg <= '0;
            win_reg   <= '0;
        end else if (!running) begin
            presc_reg <= '0;
            win_reg   <= '0;
        end else begin
            presc_reg <= tick ? '0 : presc_reg + 1'b1;
            if (tick)
                win_reg <= window_end ? '0 : win_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            acc_reg <= '0;
        else if (!running || window_end)
            acc_reg <= '0;
        else if (edge_cnt && !acc_reg[COUNT_W])
            acc_reg <= acc_sum;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pulse_count <= '0;
            overflow    <= 1'b0;
            count_valid <= 1'b0;
        end else begin
            count_valid <= window_end;
            if (window_end) begin
                pulse_count <= acc_sum[COUNT_W] ? {COUNT_W{1'b1}} : acc_sum[COUNT_W-1:0];
                overflow    <= acc_sum[COUNT_W];
            end
        end
    end

    assign window_active = (state_reg != IDLE);

endmodule

// File: tb/tb_pulse_window_counter.sv
// Directed bench: small 40-clk windows on the main instance, a 1000-clk single-tick-prescaler
// instance for saturation, and macro-aware expectations for the lockout feature.
module tb_pulse_window_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       pulse_in = 1'b0;
    logic [7:0] pulse_count;
    logic       count_valid;
    logic       overflow;
    logic       window_active;

    logic       big_enable = 1'b0;
    logic       big_pulse = 1'b0;
    logic [7:0] big_count;
    logic       big_valid;
    logic       big_overflow;
    logic       big_active;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobes = 0;
    int strobe_cyc = -1;
    int big_strobes = 0;
    int big_strobe_cyc = -1;

`ifdef PULSE_REFRACTORY_EN
    localparam int EXP_REF_W1 = 5;
    localparam int EXP_REF_W2 = 5;
`else
    localparam int EXP_REF_W1 = 9;
    localparam int EXP_REF_W2 = 10;
`endif

    always #5 clk = ~clk;

    pulse_window_counter #(
        .CLKS_PER_TICK(4), .WINDOW_TICKS(10), .SYNC_STAGES(2), .REFRACTORY_TICKS(2)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .pulse_in(pulse_in),
        .pulse_count(pulse_count), .count_valid(count_valid),
        .overflow(overflow), .window_active(window_active)
    );

    pulse_window_counter #(
        .CLKS_PER_TICK(1), .WINDOW_TICKS(1000), .SYNC_STAGES(2), .REFRACTORY_TICKS(1)
    ) dut_big (
        .clk(clk), .reset(reset), .enable(big_enable), .pulse_in(big_pulse),
        .pulse_count(big_count), .count_valid(big_valid),
        .overflow(big_overflow), .window_active(big_active)
    );

    always @(negedge clk) begin
        if (count_valid) begin
            strobes    = strobes + 1;
            strobe_cyc = cyc;
        end
        if (big_valid) begin
            big_strobes    = big_strobes + 1;
            big_strobe_cyc = cyc;
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
        end
    endtask

    task automatic run_until(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic pulse_at(input int c);
        run_until(c);
        pulse_in = 1'b1;
        step(1);
        pulse_in = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            pulse_in = ~pulse_in;
            step(1);
        end
        checks++; if (pulse_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", pulse_count); end
        checks++; if (count_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", count_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        checks++; if (window_active !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", window_active); end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pulse_in = ~pulse_in;
            step(1);
        end
        pulse_in = 1'b0;
        step(4);
        checks++; if (window_active !== 1'b0) begin errors++; $display("FAIL idle_active got %b want 0", window_active); end
        checks++; if (pulse_count !== 8'd0) begin errors++; $display("FAIL idle_count got %0d want 0", pulse_count); end
        checks++; if (strobes !== 0) begin errors++; $display("FAIL idle_strobes got %0d want 0", strobes); end
        checks++; if (big_count !== 8'd0 || big_active !== 1'b0) begin errors++; $display("FAIL idle_big got %0d/%b want 0/0", big_count, big_active); end
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_count_basic();
        enable = 1'b1;
        step(1);
        cyc = 0;
        checks++; if (window_active !== 1'b1) begin errors++; $display("FAIL armed_active got %b want 1", window_active); end
        pulse_at(5);
        pulse_at(12);
        pulse_at(20);
        run_until(40);
        checks++; if (count_valid !== 1'b1) begin errors++; $display("FAIL w1_valid_at40 got %b want 1", count_valid); end
        run_until(41);
        checks++; if (count_valid !== 1'b0) begin errors++; $display("FAIL w1_valid_at41 got %b want 0", count_valid); end
        checks++; if (strobes !== 1 || strobe_cyc !== 40) begin errors++; $display("FAIL w1_strobe got n=%0d cyc=%0d want n=1 cyc=40", strobes, strobe_cyc); end
        checks++; if (pulse_count !== 8'd3) begin errors++; $display("FAIL w1_count got %0d want 3", pulse_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL w1_overflow got %b want 0", overflow); end
        run_until(81);
        checks++; if (strobes !== 2 || strobe_cyc !== 80) begin errors++; $display("FAIL w2_strobe got n=%0d cyc=%0d want n=2 cyc=80", strobes, strobe_cyc); end
        checks++; if (pulse_count !== 8'd0) begin errors++; $display("FAIL w2_empty_count got %0d want 0", pulse_count); end
        $display("test_count_basic done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_window_end_edge();
        // Edge lands in cycle 119 (window_end); a second edge at 121 opens the next window.
        pulse_at(117);
        pulse_at(119);
        run_until(121);
        checks++; if (strobe_cyc !== 120) begin errors++; $display("FAIL w3_strobe_cyc got %0d want 120", strobe_cyc); end
        checks++; if (pulse_count !== 8'd1) begin errors++; $display("FAIL w3_end_edge_count got %0d want 1", pulse_count); end
        run_until(161);
        checks++; if (strobe_cyc !== 160) begin errors++; $display("FAIL w4_strobe_cyc got %0d want 160", strobe_cyc); end
        checks++; if (pulse_count !== 8'd1) begin errors++; $display("FAIL w4_fresh_count got %0d want 1", pulse_count); end
        $display("test_window_end_edge done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_enable_drop();
        int snap;
        pulse_at(165);
        pulse_at(170);
        run_until(180);
        enable = 1'b0;
        snap = strobes;
        run_until(230);
        checks++; if (strobes !== snap) begin errors++; $display("FAIL drop_strobe got %0d want %0d", strobes, snap); end
        checks++; if (pulse_count !== 8'd1) begin errors++; $display("FAIL drop_held_count got %0d want 1", pulse_count); end
        checks++; if (window_active !== 1'b0) begin errors++; $display("FAIL drop_active got %b want 0", window_active); end
        enable = 1'b1;
        step(1);
        cyc = 0;
        pulse_at(5);
        pulse_at(10);
        pulse_at(15);
        pulse_at(20);
        run_until(41);
        checks++; if (strobes !== snap + 1 || strobe_cyc !== 40) begin errors++; $display("FAIL rearm_strobe got n=%0d cyc=%0d want n=%0d cyc=40", strobes, strobe_cyc, snap + 1); end
        checks++; if (pulse_count !== 8'd4) begin errors++; $display("FAIL rearm_count got %0d want 4", pulse_count); end
        // Reset in the middle of the following window.
        pulse_at(62);
        run_until(66);
        reset = 1'b1;
        step(1);
        checks++; if (pulse_count !== 8'd0 || overflow !== 1'b0) begin errors++; $display("FAIL midreset_outputs got %0d/%b want 0/0", pulse_count, overflow); end
        checks++; if (window_active !== 1'b0 || count_valid !== 1'b0) begin errors++; $display("FAIL midreset_flags got %b/%b want 0/0", window_active, count_valid); end
        step(2);
        reset = 1'b0;
        $display("test_enable_drop done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_refractory();
        step(1);
        cyc = 0;
        for (int j = 3; j <= 39; j += 4) pulse_at(j);
        run_until(41);
        checks++; if (strobe_cyc !== 40) begin errors++; $display("FAIL ref_w1_strobe_cyc got %0d want 40", strobe_cyc); end
        checks++; if (pulse_count !== 8'(EXP_REF_W1)) begin errors++; $display("FAIL ref_w1_count got %0d want %0d", pulse_count, EXP_REF_W1); end
        for (int j = 43; j <= 83; j += 4) pulse_at(j);
        run_until(81);
        checks++; if (pulse_count !== 8'(EXP_REF_W2)) begin errors++; $display("FAIL ref_w2_count got %0d want %0d", pulse_count, EXP_REF_W2); end
        enable = 1'b0;
        $display("test_refractory done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_saturation();
        big_enable = 1'b1;
        step(1);
        cyc = 0;
        while (cyc < 990) begin
            big_pulse = cyc[0];
            step(1);
        end
        big_pulse = 1'b0;
        run_until(1001);
        checks++; if (big_strobes !== 1 || big_strobe_cyc !== 1000) begin errors++; $display("FAIL sat_strobe got n=%0d cyc=%0d want n=1 cyc=1000", big_strobes, big_strobe_cyc); end
        checks++; if (big_count !== 8'd255) begin errors++; $display("FAIL sat_count got %0d want 255", big_count); end
        checks++; if (big_overflow !== 1'b1) begin errors++; $display("FAIL sat_overflow got %b want 1", big_overflow); end
        run_until(1100); big_pulse = 1'b1; step(1); big_pulse = 1'b0;
        run_until(1200); big_pulse = 1'b1; step(1); big_pulse = 1'b0;
        run_until(2001);
        checks++; if (big_strobe_cyc !== 2000) begin errors++; $display("FAIL sat_next_strobe got %0d want 2000", big_strobe_cyc); end
        checks++; if (big_count !== 8'd2 || big_overflow !== 1'b0) begin errors++; $display("FAIL sat_next got %0d/%b want 2/0", big_count, big_overflow); end
        $display("test_saturation done: checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        test_reset();
        test_count_basic();
        test_window_end_edge();
        test_enable_drop();
        test_refractory();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
